// File: rtl/bcd_counter_pkg.sv
// Shared constants and types for the prescaled BCD counter and its display decode.
package bcd_counter_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t DIGIT_MAX = 4'd9;
  localparam bcd_t DIGIT_MIN = 4'd0;

  // gfedcba, active-high
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic [6:0] seg_encode(input bcd_t d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/seg7.sv
// BCD digit to gfedcba 7-segment pattern; non-BCD codes show blank.
module seg7
  import bcd_counter_pkg::*;
(
  input  bcd_t       digit,
  output logic [6:0] segments
);

  assign segments = seg_encode(digit);

endmodule

// File: rtl/bcd_tick_counter.sv
// Prescaled multi-digit BCD up/down counter with wrap flag and a
// time-multiplexed 7-segment scan output.
module bcd_tick_counter
  import bcd_counter_pkg::*;
#(
  parameter int                    NUM_DIGITS = 4,
  parameter int                    TICK_WIDTH = 24,
  parameter logic [TICK_WIDTH-1:0] MAX_COUNT  = TICK_WIDTH'(24'd10_000_000),
  parameter int                    SCAN_DIV   = 10_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    clear,
  input  logic                    down,
  input  logic [TICK_WIDTH-1:0]   prescale_cmp,
  output logic [NUM_DIGITS*4-1:0] count_bcd,
  output logic                    tick,
  output logic                    wrap,
  output logic [6:0]              segments,
  output logic [NUM_DIGITS-1:0]   digit_sel
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  logic [TICK_WIDTH-1:0]   cmp;
  logic [TICK_WIDTH-1:0]   pre_cnt;
  logic                    step;
  logic [NUM_DIGITS*4-1:0] count_q;
  logic [NUM_DIGITS*4-1:0] count_next;
  logic [NUM_DIGITS-1:0]   at_limit;
  logic [NUM_DIGITS-1:0]   carry_in;
  logic                    wrap_next;

  assign cmp  = (prescale_cmp == '0) ? MAX_COUNT : prescale_cmp;
  // >= rather than == so lowering cmp below pre_cnt steps at once
  assign step = en && (pre_cnt >= cmp);

  // Carry/borrow into digit g is the AND of all lower digits being at their limit.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    bcd_t cur;
    assign cur         = count_q[4*g +: 4];
    assign at_limit[g] = down ? (cur == DIGIT_MIN) : (cur == DIGIT_MAX);

    if (g == 0) begin : g_lsd
      assign carry_in[g] = 1'b1;
    end else begin : g_upper
      assign carry_in[g] = &at_limit[g-1:0];
    end

    always_comb begin
      count_next[4*g +: 4] = cur;
      if (carry_in[g]) begin
        if (at_limit[g]) count_next[4*g +: 4] = down ? DIGIT_MAX : DIGIT_MIN;
        else             count_next[4*g +: 4] = down ? (cur - 4'd1) : (cur + 4'd1);
      end
    end
  end

  assign wrap_next = &at_limit;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      count_q <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else if (clear) begin
      pre_cnt <= '0;
      count_q <= '0;
      tick    <= 1'b0;
      wrap    <= 1'b0;
    end else begin
      tick <= 1'b0;
      wrap <= 1'b0;
      if (step) begin
        pre_cnt <= '0;
        count_q <= count_next;
        tick    <= 1'b1;
        wrap    <= wrap_next;
      end else if (en) begin
        pre_cnt <= pre_cnt + TICK_WIDTH'(1);
      end
    end
  end

  assign count_bcd = count_q;

  // Display scan runs independently of en/clear.
  logic [SCAN_W-1:0]     scan_cnt;
  logic [NUM_DIGITS-1:0] sel_rot;
  bcd_t                  scan_digit;

  always_comb begin
    sel_rot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) sel_rot[(i + 1) % NUM_DIGITS] = digit_sel[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_cnt  <= '0;
      digit_sel <= NUM_DIGITS'(1);
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt  <= '0;
      digit_sel <= sel_rot;
    end else begin
      scan_cnt  <= scan_cnt + SCAN_W'(1);
    end
  end

  always_comb begin
    scan_digit = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_sel[i]) scan_digit = scan_digit | count_q[4*i +: 4];
    end
  end

  seg7 u_seg7 (
    .digit    (scan_digit),
    .segments (segments)
  );

endmodule

// File: tb/tb_bcd_tick_counter.sv
// Directed bench for bcd_tick_counter: prescale, carry/borrow, wrap, hold,
// clear, compare lowering, scan rotation and reset.
module tb_bcd_tick_counter;

  logic        clk = 1'b0;
  logic        rst_n, en, clear, down;
  logic [23:0] prescale_cmp;
  logic [15:0] count_bcd;
  logic        tick, wrap;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;

  int n_cmp = 0;
  int n_err = 0;
  logic [10:0] exp_q[$];

  always #5 clk = ~clk;

  bcd_tick_counter #(
    .NUM_DIGITS (4),
    .TICK_WIDTH (24),
    .MAX_COUNT  (24'd3),
    .SCAN_DIV   (3)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .clear        (clear),
    .down         (down),
    .prescale_cmp (prescale_cmp),
    .count_bcd    (count_bcd),
    .tick         (tick),
    .wrap         (wrap),
    .segments     (segments),
    .digit_sel    (digit_sel)
  );

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expected);
    n_cmp++;
    assert (obs === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expected);
    end
  endtask

  task automatic wait_tick(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 64; i++) begin
      cyc(1);
      if (tick === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      n_cmp++;
      n_err++;
      $error("FAIL %s: observed no tick expected tick within 64 cycles", tag);
    end
  endtask

  initial begin
    logic [3:0]  prev_sel;
    int          changes;
    bit          hold_tick_seen;
    bit          synced;
    logic [10:0] e;

    rst_n = 1'b0; en = 1'b0; clear = 1'b0; down = 1'b0; prescale_cmp = 24'd4;
    cyc(2);
    chk("rst_count", count_bcd, 16'h0000);
    chk("rst_tick", tick, 1'b0);
    chk("rst_wrap", wrap, 1'b0);
    chk("rst_sel", digit_sel, 4'b0001);
    chk("rst_seg", segments, 7'b0111111);
    rst_n = 1'b1;

    // cmp = 4: period 5
    en = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cyc(1);
      chk("pre4_tick", tick, (k % 5 == 0));
    end
    chk("pre4_count", count_bcd, 16'h0004);

    // prescale_cmp = 0 selects MAX_COUNT = 3: period 4
    prescale_cmp = 24'd0;
    for (int k = 1; k <= 8; k++) begin
      cyc(1);
      chk("max_tick", tick, (k % 4 == 0));
    end
    chk("max_count", count_bcd, 16'h0006);

    // Fast period 2 for bulk counting
    prescale_cmp = 24'd1;
    for (int k = 0; k < 93; k++) wait_tick("to_0099");
    chk("up_0099", count_bcd, 16'h0099);
    wait_tick("carry");
    chk("up_0100", count_bcd, 16'h0100);
    chk("up_0100_wrap", wrap, 1'b0);

    down = 1'b1;
    wait_tick("borrow");
    chk("dn_0099", count_bcd, 16'h0099);
    chk("dn_0099_wrap", wrap, 1'b0);
    for (int k = 0; k < 99; k++) wait_tick("to_0000");
    chk("dn_0000", count_bcd, 16'h0000);
    wait_tick("underflow");
    chk("dn_9999", count_bcd, 16'h9999);
    chk("dn_wrap", wrap, 1'b1);
    chk("dn_wrap_tick", tick, 1'b1);
    cyc(1);
    chk("dn_wrap_pulse", wrap, 1'b0);
    chk("dn_tick_pulse", tick, 1'b0);
    chk("dn_9999_hold", count_bcd, 16'h9999);

    down = 1'b0;
    wait_tick("overflow");
    chk("up_0000", count_bcd, 16'h0000);
    chk("up_wrap", wrap, 1'b1);
    cyc(1);
    chk("up_wrap_pulse", wrap, 1'b0);

    // down only matters on the step cycle
    down = 1'b1;
    wait_tick("dir_sync");
    chk("dir_sync_count", count_bcd, 16'h9999);
    down = 1'b1;
    cyc(1);
    chk("dir_between", count_bcd, 16'h9999);
    down = 1'b0;
    cyc(1);
    chk("dir_step_up", count_bcd, 16'h0000);
    chk("dir_step_wrap", wrap, 1'b1);

    // Hold
    prescale_cmp = 24'd4;
    cyc(2);
    chk("hold_pre_start", dut.pre_cnt, 24'd2);
    en = 1'b0;
    prev_sel = digit_sel;
    changes = 0;
    hold_tick_seen = 1'b0;
    for (int k = 0; k < 50; k++) begin
      cyc(1);
      if (digit_sel !== prev_sel) changes++;
      if (tick !== 1'b0) hold_tick_seen = 1'b1;
      prev_sel = digit_sel;
    end
    chk("hold_count", count_bcd, 16'h0000);
    chk("hold_pre", dut.pre_cnt, 24'd2);
    chk("hold_no_tick", hold_tick_seen, 1'b0);
    chk("hold_scan_runs", (changes >= 16), 1'b1);

    // Clear coincident with a due step
    en = 1'b1;
    cyc(2);
    chk("clr_pre_due", dut.pre_cnt, 24'd4);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clr_count", count_bcd, 16'h0000);
    chk("clr_tick", tick, 1'b0);
    chk("clr_wrap", wrap, 1'b0);
    chk("clr_pre", dut.pre_cnt, 24'd0);
    cyc(4);
    chk("clr_no_early_tick", tick, 1'b0);
    cyc(1);
    chk("clr_next_tick", tick, 1'b1);
    chk("clr_next_count", count_bcd, 16'h0001);

    // Lowering compare below pre_cnt steps immediately
    prescale_cmp = 24'd20;
    cyc(10);
    chk("low_pre10", dut.pre_cnt, 24'd10);
    chk("low_no_tick", tick, 1'b0);
    prescale_cmp = 24'd2;
    cyc(1);
    chk("low_tick", tick, 1'b1);
    chk("low_count", count_bcd, 16'h0002);
    chk("low_pre0", dut.pre_cnt, 24'd0);

    // Scan of 1234
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    prescale_cmp = 24'd1;
    for (int k = 0; k < 1234; k++) wait_tick("to_1234");
    en = 1'b0;
    chk("scan_count", count_bcd, 16'h1234);
    synced = 1'b0;
    for (int k = 0; k < 20; k++) begin
      prev_sel = digit_sel;
      cyc(1);
      if (digit_sel === 4'b0001 && prev_sel !== 4'b0001) begin
        synced = 1'b1;
        break;
      end
    end
    chk("scan_sync", synced, 1'b1);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back({4'b0001, 7'b1100110});
      exp_q.push_back({4'b0010, 7'b1001111});
      exp_q.push_back({4'b0100, 7'b1011011});
      exp_q.push_back({4'b1000, 7'b0000110});
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      for (int c = 0; c < 3; c++) begin
        chk("scan_sel", digit_sel, e[10:7]);
        chk("scan_seg", segments, e[6:0]);
        cyc(1);
      end
    end

    // Reset mid-count
    en = 1'b1;
    cyc(1);
    rst_n = 1'b0;
    cyc(2);
    chk("mrst_count", count_bcd, 16'h0000);
    chk("mrst_tick", tick, 1'b0);
    chk("mrst_wrap", wrap, 1'b0);
    chk("mrst_sel", digit_sel, 4'b0001);
    chk("mrst_seg", segments, 7'b0111111);
    rst_n = 1'b1;
    cyc(1);
    chk("mrst_first_wait", count_bcd, 16'h0000);
    cyc(1);
    chk("mrst_first_tick", tick, 1'b1);
    chk("mrst_first_count", count_bcd, 16'h0001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bcd_tick_counter.md
# bcd_tick_counter

Parametrised successor to the single-digit seconds counter: a prescaled, multi-digit BCD up/down counter with hold, synchronous clear, wrap flag and a time-multiplexed 7-segment scan output. It sits between the top-level pad wrapper and the display. The wrapper supplies the clock, the prescale compare value from the input switches, and the control bits. The block drives the segment lines and the one-hot digit select for a common multi-digit display.

## Interface
- `NUM_DIGITS`, 4: number of BCD digits; 1..8.
- `TICK_WIDTH`, 24: prescaler width in bits.
- `MAX_COUNT`, 24'd10_000_000: compare value used when `prescale_cmp` is 0.
- `SCAN_DIV`, 10_000: clock cycles each digit is shown; ≥1.

- `clk` in 1: system clock.
- `rst_n` in 1: **one clock; reset is synchronous and active-low**.
- `en` in 1: count enable; low freezes the prescaler and digits.
- `clear` in 1: synchronous clear of the prescaler and digits.
- `down` in 1: 0 = count up, 1 = count down.
- `prescale_cmp` in TICK_WIDTH: tick compare value; 0 selects `MAX_COUNT`.
- `count_bcd` out NUM_DIGITS*4: digit i at bits [4i+3:4i]; digit 0 is least significant.
- `tick` out 1: one-cycle pulse, coincident with each count update.
- `wrap` out 1: one-cycle pulse on overflow (up) or underflow (down).
- `segments` out 7: gfedcba pattern of the currently scanned digit, active-high.
- `digit_sel` out NUM_DIGITS: one-hot, active-high scan select.

## Operation
- **Compare value:** `cmp = (prescale_cmp == 0) ? MAX_COUNT : prescale_cmp`. It is evaluated combinationally every cycle.
- **Prescaler:**
  - When `en` is high, it increments each cycle.
  - When `en` is high and `pre_cnt >= cmp`, it reloads 0 and a step occurs instead of incrementing.
  - Tick period is therefore cmp+1 cycles.
  - The `>=` compare means that lowering `cmp` below the current count forces an immediate step. There is no 2^TICK_WIDTH runaway.
- **Step, up:**
  - Digit 0 increments. A digit at 9 becomes 0 and carries into the next digit.
  - All digits at 9 → all digits 0, and `wrap` is asserted.
- **Step, down:**
  - Digit 0 decrements. A digit at 0 becomes 9 and borrows from the next digit.
  - All digits at 0 → all digits 9, and `wrap` is asserted.
- **Direction:** `down` is sampled at the step cycle only. Changing it between steps never alters the stored count.
- **Priority:** `rst_n` low > `clear` > `en`.
  - `clear` zeroes the digits and `pre_cnt` regardless of `en`.
  - `clear` suppresses any coincident step, so neither `tick` nor `wrap` pulses.
- **Hold:** with `en` low, `pre_cnt`, the digits, `tick` and `wrap` are held at their values / 0. The display scan keeps running.
- **Digit values:** digits always hold 0..9. No non-BCD value is reachable.
- **Scan:**
  - A free-running scan counter of SCAN_DIV cycles advances `digit_sel` by one-hot rotation 0→1→…→NUM_DIGITS-1→0.
  - It ignores `en` and `clear`.
  - With NUM_DIGITS = 1, `digit_sel` is constantly 1.
- **Segments:** `segments` = seg7 decode of the digit selected by `digit_sel`.

## Timing
- **Reset values** (`rst_n` sampled low at a rising edge):
  - `pre_cnt` = 0; all digits = 0, so `count_bcd` = 0.
  - `tick` = 0, `wrap` = 0.
  - scan counter = 0, `digit_sel` = 1 (digit 0).
  - `segments` = 7'b0111111 ("0").
- **Reset mid-operation:** all of the above apply from the next edge; pending steps are dropped.
- **Step latency:** the edge where `pre_cnt >= cmp` and `en` is high updates `count_bcd`, and registers `tick` = 1 and `wrap` if applicable. All three change on the same edge, with zero skew between them.
- **First tick after reset** (`en` held high): `count_bcd` becomes 1 after cmp+1 enabled cycles.
- **`clear`:** takes effect on the next edge. Counting restarts from `pre_cnt` = 0, so the next tick follows cmp+1 enabled cycles later.
- **Scan timing:** `digit_sel` changes every SCAN_DIV cycles. `segments` follows within the same cycle, because the decode is combinational from registered state.

## Structure
- **Shared package** `bcd_counter_pkg` holds:
  - the BCD constants (DIGIT_MAX = 4'd9);
  - the 7-segment codes for 0..9 and a blank code;
  - the type for a 4-bit BCD digit.
- **Sub-module:** reuse the existing `seg7` decoder (4-bit digit in → 7-bit segments out) as a single instance on the scanned digit.
- **Per-digit logic:** up/down with carry/borrow, built as a generate loop, not a separate module.

## Test plan
- **Reset:** hold `rst_n` low 2 cycles mid-count → `count_bcd` = 0, `tick` = `wrap` = 0, `digit_sel` = 4'b0001, `segments` = 7'b0111111.
- **Prescale:** `prescale_cmp` = 4, `en` = 1, up, run 20 cycles → `tick` every 5 cycles; `count_bcd` = 16'h0004 after 20 cycles. Repeat with `prescale_cmp` = 0 and a bench `MAX_COUNT` = 3 → period 4.
- **Up wrap:** preload 16'h0099 via ticks → next tick gives 16'h0100. Reach 16'h9999 → next tick gives 16'h0000 with `wrap` = 1 for exactly 1 cycle, coincident with `tick`.
- **Down borrow:** from 16'h0100 with `down` = 1 → 16'h0099. From 16'h0000 → 16'h9999 with `wrap` = 1.
- **Hold and clear:**
  - `en` = 0 for 50 cycles → `count_bcd` and `pre_cnt` unchanged, `digit_sel` still rotates.
  - `clear` asserted in the same cycle as a due step → `count_bcd` = 0, no `tick`/`wrap` pulse.
  - Lower `prescale_cmp` from 20 to 2 while `pre_cnt` = 10 → step on the next edge.
- **Scan:** `SCAN_DIV` = 3, count = 16'h1234 → `digit_sel` cycles 0001, 0010, 0100, 1000 every 3 cycles, with `segments` = codes for 4, 3, 2, 1 respectively.
